pfb_circ_shift_buffer: RTL and testbench
========================================

// Module: pfb_circ_shift_buffer
// PURPOSE
//  Parametrised circular-shift ping-pong buffer between the PFB filter output and the FFT.
//  - Captures one fft_size-sample frame per buffer, addressed by input phase.
//  - Reads each frame out rotated by a per-frame offset that advances by shift_step every output frame.
//    With shift_step = fft_size/2 this gives the 2x-oversampled alternating half shift.
//  - Adds runtime power-of-two FFT size, AXI-Stream tready backpressure, and frame-drop overflow reporting.
// PARAMETERS
//  DATA_W     36  sample width (I/Q packed)
//  MAX_LOG2    9  log2 of the largest FFT size; RAM depth is 2**MAX_LOG2
//  MIN_LOG2    3  log2 of the smallest legal FFT size
//  RAM_LAT     3  RAM read latency in cycles (raddr to dout), >= 1
//  SKID_D     RAM_LAT+2  output FIFO depth
// PORTS
//  clk            in   1         single clock
//  sync_reset     in   1         reset: asynchronous, active-high
//  fft_size_log2  in   4         log2 FFT size, MIN_LOG2..MAX_LOG2
//  shift_step     in   MAX_LOG2  per-frame offset increment; only the low fft_size_log2 bits are used
//  phase          in   MAX_LOG2  write address of input_sig
//  input_sig      in   DATA_W    input sample
//  valid_i        in   1         input beat qualifier; no backpressure toward the filter
//  m_axis_tdata   out  DATA_W    output sample
//  m_axis_tvalid  out  1         output valid
//  m_axis_tready  in   1         output ready
//  m_axis_tlast   out  1         last sample of the output frame
//  overflow       out  1         1-cycle pulse per dropped frame
// BEHAVIOUR
//  - Reset: tdata=0, tvalid=0, tlast=0, overflow=0; both buffers empty; wr_sel=0; offset=0; FIFO empty; rd FSM IDLE.
//    Reset mid-operation discards all pending data.
//  - mask = 2**fft_size_log2 - 1. Phase and read addresses use the low fft_size_log2 bits.
//    fft_size_log2 and shift_step are legal to change only while both buffers are empty and tvalid=0; otherwise undefined.
//  - Frame start: first valid_i beat after reset or after a frame-end beat. Frame end: valid_i && (phase & mask) == mask.
//  - Write:
//    - Frame start with buf[wr_sel] free: frame is accepted.
//      Each beat writes buf[wr_sel][phase] one cycle later (registered).
//      Frame end marks buf[wr_sel] full and toggles wr_sel.
//    - Frame start with buf[wr_sel] full: frame is dropped. All writes are suppressed, wr_sel is not toggled.
//      overflow pulses 1 cycle after that frame's end beat.
//    - A buffer freed in the same cycle as a frame-start beat counts as free.
//  - Read FSM:
//    - IDLE -> READ when buf[rd_sel] is full. Latch off = offset and rd_cnt = 0.
//    - READ issues raddr = (rd_cnt + off) & mask only when FIFO occupancy plus in-flight reads < SKID_D, then rd_cnt++.
//    - When rd_cnt == mask is issued:
//      - buf[rd_sel] becomes free, rd_sel toggles, offset <= (offset + shift_step) & mask.
//      - If the other buffer is full, stay in READ with rd_cnt = 0 (no gap); else go to IDLE.
//    - tlast travels with the rd_cnt == mask word.
//  - Output: FIFO head drives tdata/tvalid/tlast. Pop on tvalid && tready. tdata/tlast hold while tvalid && !tready.
//  - Latency: the last input beat of a frame is cycle 0. First raddr is issued in cycle 2.
//    With tready high, first tvalid is in cycle RAM_LAT+3 (6 at default).
//  - Throughput: 1 sample per clock sustained with tready high. Consecutive frames stream back-to-back.
//  - Read-after-write: the RAM returns data written at least 1 cycle before the read address issue.
// STRUCTURE
//  - Include pfb_circ_defs.vh: FSM state encodings (S_IDLE, S_READ), LOG2_W=4, MIN_LOG2/MAX_LOG2 limits.
//  - Sub-module circ_sdp_ram: parametrised simple dual-port RAM (DATA_W, depth 2**MAX_LOG2, RAM_LAT), instantiated twice.
//  - Output FIFO is inline logic (register array plus pointers), not a separate module.
// TESTING
//  - Reset, N=256, shift_step=128, ramp data d=p, tready=1:
//    - frame0 out 0..255; frame1 out 128..255,0..127; tlast on every 256th beat.
//    - First tvalid 6 cycles after input beat 255.
//  - N=8, shift_step=3, 4 back-to-back frames:
//    - Output start addrs 0,3,6,1.
//    - tvalid continuous, no bubble between frames.
//  - N=512, tready toggling 1/0 pseudo-random:
//    - No lost or duplicated samples; tdata stable while stalled; order matches model.
//  - N=16, tready=0 for 3 full input frames:
//    - Frames 0,1 buffered; frame 2 dropped with one overflow pulse.
//    - Releasing tready outputs frames 0,1 only; offset advanced twice.
//  - Assert sync_reset mid-output:
//    - tvalid drops asynchronously; the next frame is output from offset 0 with no stale data.

Source files
------------

// File: rtl/pfb_circ_shift_buffer_pkg.sv
// rtl/pfb_circ_shift_buffer_pkg.sv - shared limits and read FSM encoding for the circular-shift buffer
package pfb_circ_shift_buffer_pkg;

  localparam int LOG2_W       = 4;
  localparam int MIN_LOG2_LIM = 3;
  localparam int MAX_LOG2_LIM = 9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/pfb_circ_shift_buffer_ram.sv
// rtl/pfb_circ_shift_buffer_ram.sv - simple dual-port RAM with a RAM_LAT-deep registered read path
module circ_sdp_ram #(
  parameter int DATA_W  = 36,
  parameter int ADDR_W  = 9,
  parameter int RAM_LAT = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem  [2**ADDR_W];
  logic [DATA_W-1:0] pipe [RAM_LAT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    pipe[0] <= mem[raddr];
    for (int k = 1; k < RAM_LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign rdata = pipe[RAM_LAT-1];

endmodule

// File: rtl/pfb_circ_shift_buffer.sv
// rtl/pfb_circ_shift_buffer.sv - ping-pong frame buffer read out with a per-frame circular rotation
module pfb_circ_shift_buffer
  import pfb_circ_shift_buffer_pkg::*;
#(
  parameter int DATA_W   = 36,
  parameter int MAX_LOG2 = MAX_LOG2_LIM,
  parameter int MIN_LOG2 = MIN_LOG2_LIM,
  parameter int RAM_LAT  = 3,
  parameter int SKID_D   = RAM_LAT + 2
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic [LOG2_W-1:0]   fft_size_log2,
  input  logic [MAX_LOG2-1:0] shift_step,
  input  logic [MAX_LOG2-1:0] phase,
  input  logic [DATA_W-1:0]   input_sig,
  input  logic                valid_i,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                overflow
);

  localparam int PTR_W = (SKID_D > 1) ? $clog2(SKID_D) : 1;
  localparam int CNT_W = $clog2(SKID_D + 1) + 1;

  logic [MAX_LOG2-1:0] mask;
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LOG2; i++)
      mask[i] = (i < MIN_LOG2) || (i < int'(fft_size_log2));
  end

  // ---------------- write side ----------------
  logic [1:0]          buf_full, buf_full_nxt;
  logic                wr_sel, rd_sel, mid_frame, drop_q;
  logic                wr_vld_q, wr_sel_q;
  logic [MAX_LOG2-1:0] wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                frame_start, frame_end, wr_buf_free, drop_now;
  logic                last_issue;

  assign frame_start = valid_i && !mid_frame;
  assign frame_end   = valid_i && ((phase & mask) == mask);
  // The reader releasing this buffer on the same edge makes it available.
  assign wr_buf_free = !buf_full[wr_sel] || (last_issue && (rd_sel == wr_sel));
  assign drop_now    = frame_start ? !wr_buf_free : drop_q;

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      mid_frame <= 1'b0;
      drop_q    <= 1'b0;
      wr_sel    <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_vld_q  <= valid_i && !drop_now;
      wr_sel_q  <= wr_sel;
      wr_addr_q <= phase & mask;
      wr_data_q <= input_sig;
      overflow  <= frame_end && drop_now;
      if (valid_i) begin
        mid_frame <= !frame_end;
        drop_q    <= drop_now;
        if (frame_end && !drop_now) wr_sel <= !wr_sel;
      end
    end
  end

  always_comb begin
    buf_full_nxt = buf_full;
    if (last_issue) buf_full_nxt[rd_sel] = 1'b0;
    if (frame_end && !drop_now) buf_full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) buf_full <= '0;
    else            buf_full <= buf_full_nxt;
  end

  // ---------------- read side ----------------
  rd_state_t           state;
  logic [MAX_LOG2-1:0] offset, off, rd_cnt, raddr, next_offset;
  logic [RAM_LAT-1:0]  pipe_vld, pipe_last, pipe_sel;
  logic [CNT_W-1:0]    fifo_cnt, inflight;
  logic                issue;
  logic [DATA_W-1:0]   rdata0, rdata1, push_data;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < RAM_LAT; k++) inflight = inflight + CNT_W'(pipe_vld[k]);
  end

  // Credit check keeps every issued read guaranteed a FIFO slot.
  assign issue       = (state == S_READ) && ((fifo_cnt + inflight) < CNT_W'(SKID_D));
  assign last_issue  = issue && (rd_cnt == mask);
  assign raddr       = (rd_cnt + off) & mask;
  assign next_offset = (offset + shift_step) & mask;

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state  <= S_IDLE;
      rd_sel <= 1'b0;
      offset <= '0;
      off    <= '0;
      rd_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (buf_full[rd_sel]) begin
            state  <= S_READ;
            off    <= offset;
            rd_cnt <= '0;
          end
        end
        S_READ: begin
          if (issue) begin
            if (rd_cnt == mask) begin
              rd_sel <= !rd_sel;
              offset <= next_offset;
              off    <= next_offset;
              rd_cnt <= '0;
              if (!buf_full[!rd_sel]) state <= S_IDLE;
            end else begin
              rd_cnt <= rd_cnt + MAX_LOG2'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      pipe_sel  <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= last_issue;
      pipe_sel[0]  <= rd_sel;
      for (int k = 1; k < RAM_LAT; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_last[k] <= pipe_last[k-1];
        pipe_sel[k]  <= pipe_sel[k-1];
      end
    end
  end

  circ_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(MAX_LOG2), .RAM_LAT(RAM_LAT)) u_ram0 (
    .clk   (clk),
    .we    (wr_vld_q && !wr_sel_q),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .raddr (raddr),
    .rdata (rdata0)
  );

  circ_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(MAX_LOG2), .RAM_LAT(RAM_LAT)) u_ram1 (
    .clk   (clk),
    .we    (wr_vld_q && wr_sel_q),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .raddr (raddr),
    .rdata (rdata1)
  );

  assign push_data = pipe_sel[RAM_LAT-1] ? rdata1 : rdata0;

  // ---------------- output skid FIFO ----------------
  logic [DATA_W-1:0] fifo_data [SKID_D];
  logic [SKID_D-1:0] fifo_last;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push          = pipe_vld[RAM_LAT-1];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = (fifo_cnt != '0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign m_axis_tlast  = fifo_last[rd_ptr];

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      for (int k = 0; k < SKID_D; k++) fifo_data[k] <= '0;
      fifo_last <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_last[wr_ptr] <= pipe_last[RAM_LAT-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pfb_circ_shift_buffer.sv
// tb/tb_pfb_circ_shift_buffer.sv - randomized self-checking bench for pfb_circ_shift_buffer
module tb_pfb_circ_shift_buffer;

  localparam int DW = 36;
  localparam int ML = 9;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic [3:0]    fft_size_log2;
  logic [ML-1:0] shift_step, phase;
  logic [DW-1:0] input_sig;
  logic          valid_i;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] got_q[$];
  int got_cyc[$];
  int ovf_cnt = 0, ovf_cyc = -1, first_tv_cyc = -1, stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [DW:0] prev_word = '0;

  pfb_circ_shift_buffer dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .fft_size_log2 (fft_size_log2),
    .shift_step    (shift_step),
    .phase         (phase),
    .input_sig     (input_sig),
    .valid_i       (valid_i),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!sync_reset) begin
      if (m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} != prev_word)) stall_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back({m_axis_tlast, m_axis_tdata});
        got_cyc.push_back(cyc);
      end
      if (overflow) begin
        ovf_cnt++;
        ovf_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_model();
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    ovf_cnt = 0; ovf_cyc = -1; first_tv_cyc = -1; stall_viol = 0;
  endtask

  task automatic do_reset(input int log2n, input int step);
    valid_i = 1'b0; phase = '0; input_sig = '0; m_axis_tready = 1'b1;
    fft_size_log2 = 4'(log2n);
    shift_step = ML'(step);
    sync_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 sync_reset = 1'b0;
    clear_model();
  endtask

  // Drives one frame; the final beat always carries phase == N-1. Expected output is
  // the frame rotated by 'off' with tlast on its last word.
  task automatic send_frame(input int n, input int off, input bit ramp, input bit expect_out,
                            input bit shuffle, input bit rdy_rand, output int last_cyc);
    logic [DW-1:0] d [512];
    int order [512];
    logic [63:0] r;
    int j, t;
    for (int p = 0; p < n; p++) begin
      r = {$urandom, $urandom};
      d[p] = ramp ? DW'(p) : r[DW-1:0];
      order[p] = p;
    end
    if (shuffle)
      for (int i = n - 2; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_i   = 1'b1;
      input_sig = d[order[i]];
      phase     = ML'(order[i]) | (shuffle ? (ML'($urandom) & ~ML'(n - 1)) : ML'(0));
      if (rdy_rand) m_axis_tready = 1'($urandom_range(0, 1));
    end
    last_cyc = cyc;
    if (expect_out)
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), d[(i + off) % n]});
  endtask

  task automatic idle();
    @(posedge clk); #1 valid_i = 1'b0;
  endtask

  task automatic drain(input int n_exp, input int budget, input bit rdy_rand, output bit ok);
    int c = 0;
    while (got_q.size() < n_exp && c < budget) begin
      @(posedge clk); #1;
      if (rdy_rand) m_axis_tready = 1'($urandom_range(0, 1));
      c++;
    end
    ok = (got_q.size() >= n_exp);
    m_axis_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sync_reset = 1'b1; valid_i = 1'b0; m_axis_tready = 1'b1;
    fft_size_log2 = 4'd3; shift_step = '0; phase = '0; input_sig = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_ramp_half_shift();
    int l0, l1;
    bit ok;
    do_reset(8, 128);
    send_frame(256, 0, 1'b1, 1'b1, 1'b0, 1'b0, l0);
    send_frame(256, 128, 1'b1, 1'b1, 1'b0, 1'b0, l1);
    idle();
    drain(512, 2000, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ramp_timeout got=%0d exp=512", got_q.size()); end
    checks++; if (first_tv_cyc - l0 !== 6) begin errors++; $display("FAIL ramp_latency got=%0d exp=6", first_tv_cyc - l0); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ramp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ramp_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int l;
    bit ok, gap;
    do_reset(3, 3);
    for (int k = 0; k < 4; k++) send_frame(8, (k * 3) % 8, 1'b0, 1'b1, 1'b1, 1'b0, l);
    idle();
    drain(32, 500, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got=%0d exp=32", got_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    gap = 1'b0;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[i-1] + 1) gap = 1'b1;
    checks++; if (gap !== 1'b0) begin errors++; $display("FAIL b2b_bubble got=%b exp=0", gap); end
  endtask

  task automatic test_backpressure();
    int l, step;
    bit ok;
    step = $urandom_range(0, 511);
    do_reset(9, step);
    send_frame(512, 0, 1'b0, 1'b1, 1'b1, 1'b1, l);
    send_frame(512, step % 512, 1'b0, 1'b1, 1'b1, 1'b1, l);
    idle();
    drain(1024, 6000, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=%0d exp=1024", got_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_hold got=%0d exp=0", stall_viol); end
  endtask

  task automatic test_overflow();
    int l, l2, step;
    bit ok;
    step = $urandom_range(0, 511);
    do_reset(4, step);
    m_axis_tready = 1'b0;
    send_frame(16, 0, 1'b0, 1'b1, 1'b1, 1'b0, l);
    send_frame(16, step % 16, 1'b0, 1'b1, 1'b1, 1'b0, l);
    send_frame(16, 0, 1'b0, 1'b0, 1'b1, 1'b0, l2);
    idle();
    repeat (10) @(posedge clk);
    #1;
    checks++; if (ovf_cnt !== 1) begin errors++; $display("FAIL ovf_pulses got=%0d exp=1", ovf_cnt); end
    checks++; if (ovf_cyc - l2 !== 1) begin errors++; $display("FAIL ovf_timing got=%0d exp=1", ovf_cyc - l2); end
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL ovf_held_tvalid got=%b exp=1", m_axis_tvalid); end
    drain(32, 500, 1'b0, ok);
    send_frame(16, (2 * step) % 16, 1'b0, 1'b1, 1'b1, 1'b0, l);
    idle();
    drain(48, 500, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got=%0d exp=48", got_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ovf_cnt !== 1) begin errors++; $display("FAIL ovf_extra_pulses got=%0d exp=1", ovf_cnt); end
  endtask

  task automatic test_reset_mid_output();
    int l, c;
    bit ok;
    do_reset(3, 3);
    send_frame(8, 0, 1'b0, 1'b0, 1'b1, 1'b0, l);
    send_frame(8, 3, 1'b0, 1'b0, 1'b1, 1'b0, l);
    idle();
    c = 0;
    while (got_q.size() < 3 && c < 100) begin @(posedge clk); c++; end
    checks++; if (got_q.size() < 3) begin errors++; $display("FAIL rst_mid_start got=%0d exp=3", got_q.size()); end
    @(posedge clk); #2;
    sync_reset = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_mid_tdata got=%h exp=0", m_axis_tdata); end
    do_reset(3, 3);
    send_frame(8, 0, 1'b0, 1'b1, 1'b1, 1'b0, l);
    idle();
    drain(8, 200, 1'b0, ok);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rst_mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_beat %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_half_shift();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid_output();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
